// File: rtl/hamming_dec_arb.sv
// Two-requester Hamming(7,4) decoder sharing one registered syndrome/correct stage.
// Round-robin grant, IDLE/CALC/RESP sequencing, saturating corrected/clean counters.
module hamming_dec_arb #(
    parameter bit CORRECT = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [6:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [6:0]       req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_data,
    output logic [2:0]       rsp_syn,
    output logic             rsp_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] ok_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [6:0]       cw_q, cw_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_syn_q, rsp_syn_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] ok_q, ok_d;

    logic       gnt_valid;
    logic       gnt_id;
    logic       hs;
    logic [2:0] syn;
    logic [3:0] flip_mask;
    logic [3:0] data_fix;

    // Round-robin: with both valid, the requester that did not own the last response wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign hs = (state_q == RESP) && rsp_ready;

    always_comb begin
        syn[0] = cw_q[4] ^ cw_q[3] ^ cw_q[2] ^ cw_q[0];
        syn[1] = cw_q[5] ^ cw_q[3] ^ cw_q[1] ^ cw_q[0];
        syn[2] = cw_q[6] ^ cw_q[2] ^ cw_q[1] ^ cw_q[0];
        // Parity-bit syndromes (001/010/100) leave the nibble untouched.
        case (syn)
            3'b011:  flip_mask = 4'b1000;
            3'b101:  flip_mask = 4'b0100;
            3'b110:  flip_mask = 4'b0010;
            3'b111:  flip_mask = 4'b0001;
            default: flip_mask = 4'b0000;
        endcase
        data_fix = CORRECT ? (cw_q[3:0] ^ flip_mask) : cw_q[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cw_q       <= '0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_syn_q  <= '0;
            rsp_err_q  <= 1'b0;
            corr_q     <= '0;
            ok_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cw_q       <= cw_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_syn_q  <= rsp_syn_d;
            rsp_err_q  <= rsp_err_d;
            corr_q     <= corr_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cw_d       = cw_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_syn_d  = rsp_syn_q;
        rsp_err_d  = rsp_err_q;
        last_d     = last_q;
        corr_d     = corr_q;
        ok_d       = ok_q;
        if (gnt_valid) begin
            cw_d = gnt_id ? req1_data : req0_data;
            id_d = gnt_id;
        end
        if (state_q == CALC) begin
            rsp_id_d   = id_q;
            rsp_data_d = data_fix;
            rsp_syn_d  = syn;
            rsp_err_d  = (syn != 3'b000);
        end
        if (hs) begin
            last_d = rsp_id_q;
        end
        // Clear takes priority over a same-cycle increment.
        if (clr_cnt) begin
            corr_d = '0;
            ok_d   = '0;
        end else if (hs) begin
            if (rsp_err_q) begin
                if (corr_q != CNT_MAX) corr_d = corr_q + CNT_W'(1);
            end else begin
                if (ok_q != CNT_MAX) ok_d = ok_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req0_ready = gnt_valid && !gnt_id && !rst;
        req1_ready = gnt_valid && gnt_id && !rst;
        rsp_valid  = (state_q == RESP);
        rsp_id     = rsp_id_q;
        rsp_data   = rsp_data_q;
        rsp_syn    = rsp_syn_q;
        rsp_err    = rsp_err_q;
        corr_cnt   = corr_q;
        ok_cnt     = ok_q;
    end

endmodule

// File: tb/tb_hamming_dec_arb.sv
// Directed bench: a correcting 8-bit-counter instance and a raw 2-bit-counter instance
// share the same stimulus and run in lockstep.
module tb_hamming_dec_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, rsp_ready, clr_cnt;
    logic [6:0] req0_data, req1_data;

    logic       r0_rdy, r1_rdy, rsp_valid, rsp_id, rsp_err;
    logic [3:0] rsp_data;
    logic [2:0] rsp_syn;
    logic [7:0] corr_cnt, ok_cnt;

    logic       x_r0_rdy, x_r1_rdy, x_rsp_valid, x_rsp_id, x_rsp_err;
    logic [3:0] x_rsp_data;
    logic [2:0] x_rsp_syn;
    logic [1:0] x_corr_cnt, x_ok_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hamming_dec_arb #(.CORRECT(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_syn(rsp_syn), .rsp_err(rsp_err),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .ok_cnt(ok_cnt)
    );

    hamming_dec_arb #(.CORRECT(1'b0), .CNT_W(2)) dut_raw (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(x_r0_rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(x_r1_rdy),
        .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(x_rsp_id),
        .rsp_data(x_rsp_data), .rsp_syn(x_rsp_syn), .rsp_err(x_rsp_err),
        .clr_cnt(clr_cnt), .corr_cnt(x_corr_cnt), .ok_cnt(x_ok_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction from an idle block with rsp_ready pulsed in RESP.
    task automatic run_txn(input bit id, input logic [6:0] cw, input int exp_data,
                           input int exp_syn, input int exp_raw);
        if (id) begin
            req1_valid = 1'b1; req1_data = cw;
        end else begin
            req0_valid = 1'b1; req0_data = cw;
        end
        #1;
        check("ready_granted", int'(id ? r1_rdy : r0_rdy), 1);
        check("ready_other", int'(id ? r0_rdy : r1_rdy), 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("valid_in_calc", int'(rsp_valid), 0);
        tick();
        check("rsp_valid", int'(rsp_valid), 1);
        check("rsp_id", int'(rsp_id), int'(id));
        check("rsp_data", int'(rsp_data), exp_data);
        check("rsp_syn", int'(rsp_syn), exp_syn);
        check("rsp_err", int'(rsp_err), (exp_syn != 0) ? 1 : 0);
        check("raw_data", int'(x_rsp_data), exp_raw);
        $display("txn id=%0d cw=%h data=%h raw=%h syn=%b err=%0d",
                 rsp_id, cw, rsp_data, x_rsp_data, rsp_syn, rsp_err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("valid_after_hs", int'(rsp_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        int g;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rsp_ready = 1'b0; clr_cnt = 1'b0;
        tick();
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", int'(r0_rdy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_corr", int'(corr_cnt), 0);
        check("rst_ok", int'(ok_cnt), 0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // 1: clean word from req0
        run_txn(1'b0, 7'h2B, 'hB, 0, 'hB);
        check("t1_ok", int'(ok_cnt), 1);
        check("t1_corr", int'(corr_cnt), 0);

        // 2: c2 flipped from req1
        run_txn(1'b1, 7'h2F, 'hB, 5, 'hF);
        check("t2_corr", int'(corr_cnt), 1);
        check("t2_ok", int'(ok_cnt), 1);

        // 3: both valid held, rsp_ready held high
        exp_g = '{0, 1, 0, 1};
        g = 0;
        req0_valid = 1'b1; req0_data = 7'h2B;
        req1_valid = 1'b1; req1_data = 7'h2F;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && g < 4; c++) begin
            check("t3_one_ready", int'(r0_rdy && r1_rdy), 0);
            if (r0_rdy || r1_rdy) begin
                check("t3_grant", int'(r1_rdy), exp_g[g]);
                $display("txn grant=%0d", r1_rdy);
                g++;
            end
            tick();
        end
        check("t3_grant_count", g, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 10 && !rsp_valid; c++) tick();
        check("t3_last_rsp_id", int'(rsp_id), 1);
        tick();
        rsp_ready = 1'b0;
        check("t3_ok", int'(ok_cnt), 3);
        check("t3_corr", int'(corr_cnt), 3);
        check("t3_raw_corr_sat", int'(x_corr_cnt), 3);

        // 4: backpressure in RESP with req1 waiting
        req0_valid = 1'b1; req0_data = 7'h2B;
        #1;
        check("t4_ready0", int'(r0_rdy), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 7'h2F;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", int'(rsp_valid), 1);
            check("t4_hold_id", int'(rsp_id), 0);
            check("t4_hold_data", int'(rsp_data), 'hB);
            check("t4_hold_syn", int'(rsp_syn), 0);
            check("t4_no_ready1", int'(r1_rdy), 0);
            check("t4_ok_frozen", int'(ok_cnt), 3);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4_ok_bump", int'(ok_cnt), 4);
        check("t4_ready1_after", int'(r1_rdy), 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("t4_rsp_id", int'(rsp_id), 1);
        check("t4_rsp_syn", int'(rsp_syn), 5);
        $display("txn id=%0d data=%h syn=%b", rsp_id, rsp_data, rsp_syn);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4_corr", int'(corr_cnt), 4);
        check("t4_raw_ok_sat", int'(x_ok_cnt), 3);

        // 5: saturation on the 2-bit instance, then clear racing an increment
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t5_clr_corr", int'(corr_cnt), 0);
        check("t5_clr_raw_ok", int'(x_ok_cnt), 0);
        for (int k = 1; k <= 5; k++) begin
            run_txn(1'b1, 7'h2F, 'hB, 5, 'hF);
            check("t5_corr", int'(corr_cnt), k);
            check("t5_raw_corr", int'(x_corr_cnt), (k > 3) ? 3 : k);
        end
        req1_valid = 1'b1; req1_data = 7'h2F;
        tick();
        req1_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        clr_cnt = 1'b1;
        tick();
        rsp_ready = 1'b0;
        clr_cnt = 1'b0;
        check("t5_clr_wins", int'(corr_cnt), 0);
        check("t5_raw_clr_wins", int'(x_corr_cnt), 0);

        // 6: reset while in CALC; last grant returns to 1 so req0 wins
        run_txn(1'b0, 7'h2B, 'hB, 0, 'hB);
        check("t6_ok_pre", int'(ok_cnt), 1);
        req1_valid = 1'b1; req1_data = 7'h2F;
        #1;
        check("t6_ready1", int'(r1_rdy), 1);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_async_data", int'(rsp_data), 0);
        check("t6_async_ok", int'(ok_cnt), 0);
        tick();
        check("t6_rsp_valid", int'(rsp_valid), 0);
        check("t6_rsp_data", int'(rsp_data), 0);
        check("t6_corr", int'(corr_cnt), 0);
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 7'h2B;
        req1_valid = 1'b1; req1_data = 7'h2F;
        #1;
        check("t6_grant0", int'(r0_rdy), 1);
        check("t6_not1", int'(r1_rdy), 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("t6_rsp_id", int'(rsp_id), 0);
        check("t6_rsp_data_after", int'(rsp_data), 'hB);
        $display("txn id=%0d data=%h syn=%b", rsp_id, rsp_data, rsp_syn);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t6_ok_post", int'(ok_cnt), 1);
        check("t6_corr_post", int'(corr_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
